// File: rtl/gpr_bank_if.sv
// ---------------------------------------------------------------------------
// gpr_bank_if
// Bus bundle for the general-purpose register bank.
//
//   master : drives write port W, step unit and both read selects;
//            receives read data, valid map and select-error flag.
//   slave  : the register bank side.
//
// Signals
//   load, write_select, d_in        write port W
//   inc_en, inc_select, inc_step    step unit (reg += step)
//   rd_select_a, rd_select_b        read port selects
//   rd_data_a, rd_data_b            registered read data
//   valid                           per-register "written since reset" map
//   sel_err                         out-of-range write/step select last cycle
// ---------------------------------------------------------------------------
interface gpr_bank_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int SELW  = 4
);
    logic              load;
    logic [SELW-1:0]   write_select;
    logic [WIDTH-1:0]  d_in;
    logic              inc_en;
    logic [SELW-1:0]   inc_select;
    logic [WIDTH-1:0]  inc_step;
    logic [SELW-1:0]   rd_select_a;
    logic [SELW-1:0]   rd_select_b;
    logic [WIDTH-1:0]  rd_data_a;
    logic [WIDTH-1:0]  rd_data_b;
    logic [NREGS-1:0]  valid;
    logic              sel_err;

    modport master (
        output load, write_select, d_in,
        output inc_en, inc_select, inc_step,
        output rd_select_a, rd_select_b,
        input  rd_data_a, rd_data_b, valid, sel_err
    );

    modport slave (
        input  load, write_select, d_in,
        input  inc_en, inc_select, inc_step,
        input  rd_select_a, rd_select_b,
        output rd_data_a, rd_data_b, valid, sel_err
    );
endinterface

// File: rtl/gpr_bank.sv
// ---------------------------------------------------------------------------
// gpr_bank
// Flip-flop register bank with one write port, one step (add) unit and two
// registered, write-first read ports.
//
// Ports
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-low reset
//   bus    gpr_bank_if.slave (write port, step unit, read ports, status)
//
// Parameters
//   WIDTH    data width
//   NREGS    number of registers (2..16)
//   SELW     select width, 2**SELW >= NREGS
//   R0_ZERO  1: register 0 is hard-wired to zero
// ---------------------------------------------------------------------------
module gpr_bank #(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 8,
    parameter int SELW    = 4,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    gpr_bank_if.slave   bus
);

    // One extra bit so NREGS == 2**SELW still compares correctly.
    localparam logic [SELW:0] NREGS_X = (SELW+1)'(NREGS);

    logic [WIDTH-1:0] regs      [NREGS];
    logic [WIDTH-1:0] regs_next [NREGS];
    logic [NREGS-1:0] valid_q;
    logic [NREGS-1:0] valid_next;
    logic [NREGS-1:0] wr_hit;
    logic [NREGS-1:0] inc_hit;
    logic [WIDTH-1:0] rd_a_q;
    logic [WIDTH-1:0] rd_b_q;
    logic [WIDTH-1:0] rd_a_next;
    logic [WIDTH-1:0] rd_b_next;
    logic             sel_err_q;
    logic             sel_err_next;
    logic             wr_in_range;
    logic             inc_in_range;

    assign wr_in_range  = ({1'b0, bus.write_select} < NREGS_X);
    assign inc_in_range = ({1'b0, bus.inc_select}   < NREGS_X);

    // Register 0 writes/steps under R0_ZERO are dropped without flagging.
    assign sel_err_next = (bus.load   && !wr_in_range) ||
                          (bus.inc_en && !inc_in_range);

    always_comb begin
        wr_hit  = '0;
        inc_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            wr_hit[i]  = bus.load   && (bus.write_select == SELW'(i));
            inc_hit[i] = bus.inc_en && (bus.inc_select   == SELW'(i));
        end
    end

    // Post-update register values; shared by the state update and the
    // read bypass so reads are write-first by construction.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_next[i]  = regs[i];
            valid_next[i] = valid_q[i];
            if (wr_hit[i]) begin
                regs_next[i] = bus.d_in;
            end else if (inc_hit[i]) begin
                regs_next[i] = regs[i] + bus.inc_step;
            end
            if (wr_hit[i] || inc_hit[i]) begin
                valid_next[i] = 1'b1;
            end
        end
        if (R0_ZERO) begin
            regs_next[0]  = '0;
            valid_next[0] = 1'b1;
        end
    end

    // Select decode rather than direct indexing: out-of-range selects
    // fall through to zero.
    always_comb begin
        rd_a_next = '0;
        rd_b_next = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.rd_select_a == SELW'(i)) begin
                rd_a_next = regs_next[i];
            end
            if (bus.rd_select_b == SELW'(i)) begin
                rd_b_next = regs_next[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            valid_q   <= {{(NREGS-1){1'b0}}, R0_ZERO};
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= regs_next[i];
            end
            valid_q   <= valid_next;
            rd_a_q    <= rd_a_next;
            rd_b_q    <= rd_b_next;
            sel_err_q <= sel_err_next;
        end
    end

    assign bus.rd_data_a = rd_a_q;
    assign bus.rd_data_b = rd_b_q;
    assign bus.valid     = valid_q;
    assign bus.sel_err   = sel_err_q;

endmodule
